// File: rtl/ow_pkg.sv
// Shared 1-wire definitions: slave FSM states, command codes, counter width
// and default slave timing (same time base as the master's 48000/4500/1500).
package ow_pkg;

    localparam int CNT_W = 17;

    localparam logic [7:0] CMD_WR = 8'h4E;
    localparam logic [7:0] CMD_RD = 8'hBE;

    localparam int unsigned RST_MIN_DEF   = 40000;
    localparam int unsigned PRES_WAIT_DEF = 3000;
    localparam int unsigned PRES_LEN_DEF  = 12000;
    localparam int unsigned SAMPLE_AT_DEF = 2500;
    localparam int unsigned READ_HOLD_DEF = 3000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_LOW,
        S_PRES_DLY,
        S_PRES_DRV,
        S_CMD,
        S_DECODE,
        S_RXW,
        S_TXW,
        S_HALT
    } ow_state_e;

endpackage

// File: rtl/ow_sync_edge.sv
// Two-flop bus synchronizer with a falling-edge strobe on the synced line.
module ow_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic bus_i,
    output logic bus_s,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], bus_i};
    end

    // Idle 1-wire line is high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign bus_s = sync_q[1];
    assign fall  = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ow_slave_responder.sv
// 1-wire slave: reset/presence handshake, command byte, then 16-bit
// write or read data phase over open-drain slots.
module ow_slave_responder
    import ow_pkg::*;
#(
    parameter int unsigned RST_MIN   = RST_MIN_DEF,
    parameter int unsigned PRES_WAIT = PRES_WAIT_DEF,
    parameter int unsigned PRES_LEN  = PRES_LEN_DEF,
    parameter int unsigned SAMPLE_AT = SAMPLE_AT_DEF,
    parameter int unsigned READ_HOLD = READ_HOLD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire         port,
    input  logic [15:0] tx_data,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        presence,
    output logic        busy
);

    localparam logic [CNT_W-1:0] RST_MIN_C  = CNT_W'(RST_MIN);
    localparam logic [CNT_W-1:0] PDLY_END_C = CNT_W'(PRES_WAIT - 2);
    localparam logic [CNT_W-1:0] PLEN_END_C = CNT_W'(PRES_LEN - 1);
    localparam logic [CNT_W-1:0] SAMPLE_C   = CNT_W'(SAMPLE_AT);
    localparam logic [CNT_W-1:0] HOLD_END_C = CNT_W'(READ_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_C     = CNT_W'(READ_HOLD);

    ow_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [15:0]      shift_q, shift_d;
    logic             slot_q, slot_d;
    logic             drv_q, drv_d;
    logic [15:0]      tx_q, tx_d;
    logic [7:0]       cmd_byte_q, cmd_byte_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [15:0]      rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;

    logic bus_s;
    logic fall;
    logic fall_ok;
    logic rst_hit;
    logic sample;

    ow_sync_edge u_sync (
        .clk   (clk),
        .rst_n (reset),
        .bus_i (port),
        .bus_s (bus_s),
        .fall  (fall)
    );

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        slot_d      = slot_q;
        drv_d       = drv_q;
        tx_d        = tx_q;
        cmd_byte_d  = cmd_byte_q;
        cmd_valid_d = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;

        // Our own low drive must not look like a master slot edge.
        fall_ok = fall && (state_q != S_PRES_DRV)
                  && !((state_q == S_TXW) && slot_q);
        rst_hit = !bus_s && (cnt_q >= RST_MIN_C);
        sample  = slot_q && (cnt_q == SAMPLE_C);

        unique case (state_q)
            S_IDLE: begin
                if (fall) state_d = S_RST_LOW;
            end
            S_RST_LOW: begin
                if (bus_s) begin
                    state_d = (cnt_q >= RST_MIN_C) ? S_PRES_DLY : S_IDLE;
                end
            end
            // The rise-detect cycle in RST_LOW is the first delay cycle.
            S_PRES_DLY: begin
                if (cnt_q >= PDLY_END_C) state_d = S_PRES_DRV;
            end
            S_PRES_DRV: begin
                if (cnt_q >= PLEN_END_C) begin
                    state_d = S_CMD;
                    bit_d   = 4'd0;
                    shift_d = 16'd0;
                    slot_d  = 1'b0;
                end
            end
            S_CMD, S_RXW: begin
                if (sample) begin
                    slot_d         = 1'b0;
                    shift_d[bit_q] = bus_s;
                    bit_d          = bit_q + 4'd1;
                    if (state_q == S_CMD && bit_q == 4'd7) begin
                        cmd_byte_d  = {bus_s, shift_q[6:0]};
                        cmd_valid_d = 1'b1;
                        bit_d       = 4'd0;
                        state_d     = S_DECODE;
                    end
                    if (state_q == S_RXW && bit_q == 4'd15) begin
                        rx_data_d  = {bus_s, shift_q[14:0]};
                        rx_valid_d = 1'b1;
                        state_d    = S_HALT;
                    end
                end
                if (fall_ok) slot_d = 1'b1;
            end
            S_DECODE: begin
                if (cmd_byte_q == CMD_WR) begin
                    state_d = S_RXW;
                end else if (cmd_byte_q == CMD_RD) begin
                    tx_d    = tx_data;
                    state_d = S_TXW;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_TXW: begin
                if (slot_q) begin
                    if (cnt_q == HOLD_END_C) drv_d = 1'b0;
                    if (cnt_q == HOLD_C) begin
                        slot_d = 1'b0;
                        bit_d  = bit_q + 4'd1;
                        if (bit_q == 4'd15) state_d = S_HALT;
                    end
                end else if (fall) begin
                    slot_d = 1'b1;
                    drv_d  = ~tx_q[bit_q];
                end
            end
            S_HALT: begin
            end
            default: state_d = S_IDLE;
        endcase

        if (rst_hit && state_q != S_RST_LOW) begin
            state_d     = S_RST_LOW;
            bit_d       = 4'd0;
            shift_d     = 16'd0;
            slot_d      = 1'b0;
            drv_d       = 1'b0;
            cmd_byte_d  = cmd_byte_q;
            cmd_valid_d = 1'b0;
            rx_data_d   = rx_data_q;
            rx_valid_d  = 1'b0;
        end

        // Entering RST_LOW keeps the count so an aborted reset still qualifies.
        if (fall_ok || (state_d != state_q && state_d != S_RST_LOW)) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= 4'd0;
            shift_q     <= 16'd0;
            slot_q      <= 1'b0;
            drv_q       <= 1'b0;
            tx_q        <= 16'd0;
            cmd_byte_q  <= 8'd0;
            cmd_valid_q <= 1'b0;
            rx_data_q   <= 16'd0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            slot_q      <= slot_d;
            drv_q       <= drv_d;
            tx_q        <= tx_d;
            cmd_byte_q  <= cmd_byte_d;
            cmd_valid_q <= cmd_valid_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    assign presence  = (state_q == S_PRES_DRV);
    assign busy      = (state_q != S_IDLE);
    assign cmd_byte  = cmd_byte_q;
    assign cmd_valid = cmd_valid_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;

    assign port = (presence || drv_q) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ow_slave_responder.sv
// Bench for ow_slave_responder: a behavioural 1-wire master drives
// resets and slots; expectations come from the protocol rules.
`timescale 1ns/1ps
module tb_ow_slave_responder;

    localparam int RST_MIN   = 400;
    localparam int PRES_WAIT = 30;
    localparam int PRES_LEN  = 120;
    localparam int SAMPLE_AT = 25;
    localparam int READ_HOLD = 30;

    localparam int RST_PULSE = 480;
    localparam int SHORT_LOW = 200;
    localparam int SLOT      = 80;
    localparam int PWIN      = PRES_WAIT + PRES_LEN + 20;

    localparam logic [15:0] C_WR  = 16'h004E;
    localparam logic [15:0] C_RD  = 16'h00BE;
    localparam logic [15:0] C_BAD = 16'h0033;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m_low = 1'b0;
    logic [15:0] tx_data = 16'd0;
    wire         bus;
    logic [7:0]  cmd_byte;
    logic        cmd_valid;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        presence;
    logic        busy;

    pullup (bus);
    assign bus = m_low ? 1'b0 : 1'bz;

    ow_slave_responder #(
        .RST_MIN   (RST_MIN),
        .PRES_WAIT (PRES_WAIT),
        .PRES_LEN  (PRES_LEN),
        .SAMPLE_AT (SAMPLE_AT),
        .READ_HOLD (READ_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .port      (bus),
        .tx_data   (tx_data),
        .cmd_byte  (cmd_byte),
        .cmd_valid (cmd_valid),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .presence  (presence),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_cmd = 0;
    int n_rx  = 0;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) n_cmd++;
        if (rx_valid === 1'b1) n_rx++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int len, output int pstart,
                            output int plen, output int nbusy);
        pstart = -1;
        plen   = 0;
        nbusy  = 0;
        m_low  = 1'b1;
        tick(len);
        m_low  = 1'b0;
        for (int t = 1; t <= PWIN; t++) begin
            tick(1);
            if (presence === 1'b1 && pstart < 0) pstart = t;
            if (presence === 1'b1 && bus === 1'b0) plen++;
            if (busy === 1'b1) nbusy++;
        end
    endtask

    task automatic reset_checked(input string tag);
        int ps, pl, nb;
        do_reset(RST_PULSE, ps, pl, nb);
        check({tag, "_pres_start"}, ps, PRES_WAIT + 2);
        check({tag, "_pres_len"}, pl, PRES_LEN);
        check({tag, "_pres_busy"}, nb, PWIN);
    endtask

    task automatic write_bit(input logic b);
        m_low = 1'b1;
        tick(b ? 5 : 60);
        m_low = 1'b0;
        tick(b ? SLOT - 5 : SLOT - 60);
    endtask

    task automatic write_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) write_bit(v[i]);
    endtask

    task automatic read_bit(output logic b, output int lowcnt);
        lowcnt = 0;
        b      = 1'bx;
        m_low  = 1'b1;
        for (int t = 1; t <= SLOT; t++) begin
            tick(1);
            if (bus === 1'b0) lowcnt++;
            if (t == 3) m_low = 1'b0;
            if (t == 12) b = bus;
        end
    endtask

    logic [7:0]  exp_cmd;
    logic [15:0] exp_rx;
    logic [15:0] exp_tx;
    logic [15:0] word;
    logic [15:0] got;
    logic        b;
    int          lc, c0, r0, pcnt;

    initial begin
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_presence", presence, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_cmd_byte", cmd_byte, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_wire", bus, 1);
        reset   = 1'b1;
        exp_cmd = 8'h00;
        exp_rx  = 16'h0000;
        tick(5);

        // too-short low pulse must not trigger presence
        m_low = 1'b1;
        tick(SHORT_LOW);
        m_low = 1'b0;
        pcnt  = 0;
        for (int t = 0; t < PWIN; t++) begin
            tick(1);
            if (presence === 1'b1) pcnt++;
        end
        check("short_presence", pcnt, 0);
        check("short_busy", busy, 0);

        // write command: directed word first, then random words
        for (int k = 0; k < 3; k++) begin
            word = (k == 0) ? 16'hA55A : 16'($urandom);
            c0 = n_cmd;
            r0 = n_rx;
            reset_checked("wr");
            write_bits(C_WR, 8);
            exp_cmd = C_WR[7:0];
            check("wr_cmd_byte", cmd_byte, exp_cmd);
            check("wr_cmd_pulses", n_cmd - c0, 1);
            write_bits(word, 16);
            exp_rx = word;
            check("wr_rx_data", rx_data, exp_rx);
            check("wr_rx_pulses", n_rx - r0, 1);
        end

        // read command: tx word latched at decode, later changes ignored
        for (int k = 0; k < 2; k++) begin
            exp_tx  = (k == 0) ? 16'h1234 : 16'($urandom);
            tx_data = exp_tx;
            c0 = n_cmd;
            reset_checked("rd");
            write_bits(C_RD, 8);
            exp_cmd = C_RD[7:0];
            check("rd_cmd_byte", cmd_byte, exp_cmd);
            check("rd_cmd_pulses", n_cmd - c0, 1);
            tx_data = ~exp_tx;
            got = 16'd0;
            for (int i = 0; i < 16; i++) begin
                read_bit(b, lc);
                got[i] = b;
                check("rd_low_len", lc, exp_tx[i] ? 3 : READ_HOLD + 2);
            end
            check("rd_word", got, exp_tx);
            check("rd_busy_halt", busy, 1);
        end

        // abort mid data phase
        reset_checked("ab0");
        write_bits(C_WR, 8);
        exp_cmd = C_WR[7:0];
        r0 = n_rx;
        write_bits(16'($urandom), 5);
        reset_checked("ab1");
        check("ab_rx_pulses", n_rx - r0, 0);
        check("ab_rx_data", rx_data, exp_rx);
        check("ab_cmd_byte", cmd_byte, exp_cmd);

        // unknown command parks the slave until the next reset
        c0 = n_cmd;
        reset_checked("unk");
        write_bits(C_BAD, 8);
        exp_cmd = C_BAD[7:0];
        check("unk_cmd_byte", cmd_byte, exp_cmd);
        check("unk_cmd_pulses", n_cmd - c0, 1);
        c0 = n_cmd;
        r0 = n_rx;
        write_bits(C_WR, 8);
        write_bits(16'($urandom), 16);
        for (int i = 0; i < 3; i++) begin
            read_bit(b, lc);
            check("unk_rd_low", lc, 3);
        end
        check("unk_cmd_quiet", n_cmd - c0, 0);
        check("unk_rx_quiet", n_rx - r0, 0);
        check("unk_busy", busy, 1);
        check("unk_rx_data", rx_data, exp_rx);

        // asynchronous reset while the presence pulse is driven
        m_low = 1'b1;
        tick(RST_PULSE);
        m_low = 1'b0;
        for (int t = 0; t < PRES_WAIT + 20 && presence !== 1'b1; t++) tick(1);
        check("ar_presence_on", presence, 1);
        tick(10);
        check("ar_wire_low", bus, 0);
        #2;
        reset = 1'b0;
        #1;
        check("ar_wire", bus, 1);
        check("ar_presence", presence, 0);
        check("ar_busy", busy, 0);
        check("ar_cmd_byte", cmd_byte, 0);
        check("ar_rx_data", rx_data, 0);
        check("ar_cmd_valid", cmd_valid, 0);
        check("ar_rx_valid", rx_valid, 0);
        tick(3);
        reset = 1'b1;
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
